// File: rtl/mole_spawner.sv
// Whack-a-mole placement engine: ages and retires lit moles on each game tick and
// spawns new ones at LFSR-chosen free positions. Player whacks resolve into hit/miss/wrong strobes.
module mole_spawner #(
    parameter int                    NUM_MOLES  = 5,
    parameter int                    LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'hB8,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 8'h01,
    parameter int                    MAX_ACTIVE = 1,
    parameter int                    LIFETIME   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  pulse_i,
    input  logic                  seed_load_i,
    input  logic [LFSR_WIDTH-1:0] seed_i,
    input  logic [NUM_MOLES-1:0]  whack_i,
    output logic [NUM_MOLES-1:0]  mole_position_o,
    output logic [NUM_MOLES-1:0]  hit_vec_o,
    output logic [NUM_MOLES-1:0]  miss_vec_o,
    output logic                  wrong_o
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int AGE_W = $clog2(LIFETIME + 1);
    localparam int CNT_W = $clog2(NUM_MOLES + 1);

    localparam logic [LFSR_WIDTH-1:0] NUM_L     = LFSR_WIDTH'(NUM_MOLES);
    localparam logic [IDX_W-1:0]      LAST_POS  = IDX_W'(NUM_MOLES - 1);
    localparam logic [AGE_W-1:0]      AGE_LAST  = AGE_W'(LIFETIME - 1);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_ACTIVE);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
    logic [NUM_MOLES-1:0]  mole_q, mole_d;
    logic [NUM_MOLES-1:0]  hit_q, hit_d;
    logic [NUM_MOLES-1:0]  miss_q, miss_d;
    logic                  wrong_q, wrong_d;
    logic [AGE_W-1:0]      age_q [NUM_MOLES];
    logic [AGE_W-1:0]      age_d [NUM_MOLES];
    logic [IDX_W-1:0]      last_idx_q, last_idx_d;
    logic                  last_valid_q, last_valid_d;

    logic                  pulse_acc;
    logic [NUM_MOLES-1:0]  hit_w, kept_w, expire_w, live_w, spawn_w;
    logic [CNT_W-1:0]      live_cnt;
    logic                  spawn_ok, spawn_found;
    logic [IDX_W-1:0]      cand_mod, cand, spawn_idx;

    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign pulse_acc = enable_i & pulse_i & ~seed_load_i;
    assign hit_w     = whack_i & mole_q;
    assign kept_w    = mole_q & ~whack_i;
    assign live_w    = kept_w & ~expire_w;

    // Per-mole aging: a whacked or expired mole restarts at age 0.
    generate
        for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_mole
            assign expire_w[gi] = pulse_acc & kept_w[gi] & (age_q[gi] == AGE_LAST);

            always_comb begin
                age_d[gi] = '0;
                if (enable_i && kept_w[gi] && !expire_w[gi]) begin
                    age_d[gi] = pulse_acc ? (age_q[gi] + AGE_W'(1)) : age_q[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < NUM_MOLES; i++) begin
            live_cnt = live_cnt + CNT_W'(live_w[i]);
        end
    end

    assign spawn_ok = pulse_acc && (live_cnt < MAX_CNT);
    assign cand_mod = IDX_W'(lfsr_step % NUM_L);
    // Never respawn on the position just used while the game has been running.
    assign cand = (last_valid_q && (cand_mod == last_idx_q))
                ? ((cand_mod == LAST_POS) ? '0 : (cand_mod + IDX_W'(1)))
                : cand_mod;

    always_comb begin
        int          p;
        logic [IDX_W-1:0] pi;
        spawn_found = 1'b0;
        spawn_idx   = cand;
        spawn_w     = '0;
        p           = 0;
        pi          = '0;
        for (int k = 0; k < NUM_MOLES; k++) begin
            p = int'(cand) + k;
            if (p >= NUM_MOLES) begin
                p = p - NUM_MOLES;
            end
            pi = IDX_W'(p);
            if (!spawn_found && !live_w[pi]) begin
                spawn_found = 1'b1;
                spawn_idx   = pi;
            end
        end
        if (spawn_ok && spawn_found) begin
            spawn_w[spawn_idx] = 1'b1;
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = (seed_i == '0) ? SEED : seed_i;
        end else if (pulse_acc) begin
            lfsr_d = lfsr_step;
        end

        mole_d       = '0;
        hit_d        = '0;
        miss_d       = '0;
        wrong_d      = 1'b0;
        last_idx_d   = last_idx_q;
        last_valid_d = 1'b0;
        if (enable_i) begin
            mole_d       = live_w | spawn_w;
            hit_d        = hit_w;
            miss_d       = expire_w;
            wrong_d      = |(whack_i & ~mole_q);
            last_valid_d = last_valid_q;
            if (spawn_ok && spawn_found) begin
                last_idx_d   = spawn_idx;
                last_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q       <= SEED;
            mole_q       <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            wrong_q      <= 1'b0;
            last_idx_q   <= '0;
            last_valid_q <= 1'b0;
            for (int i = 0; i < NUM_MOLES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            lfsr_q       <= lfsr_d;
            mole_q       <= mole_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            wrong_q      <= wrong_d;
            last_idx_q   <= last_idx_d;
            last_valid_q <= last_valid_d;
            for (int i = 0; i < NUM_MOLES; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign mole_position_o = mole_q;
    assign hit_vec_o       = hit_q;
    assign miss_vec_o      = miss_q;
    assign wrong_o         = wrong_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: two instances (MAX_ACTIVE 1 and 3) share stimulus; a behavioural
// model queues expected outputs per cycle, plus directed checks of the documented scenarios.
module tb_mole_spawner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, pulse, seed_load;
    logic [7:0] seed;
    logic [4:0] whack;
    logic [4:0] mole1, hit1, miss1, mole3, hit3, miss3;
    logic       wrong1, wrong3;

    always #5 clk = ~clk;

    mole_spawner dut1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .pulse_i(pulse),
        .seed_load_i(seed_load), .seed_i(seed), .whack_i(whack),
        .mole_position_o(mole1), .hit_vec_o(hit1), .miss_vec_o(miss1), .wrong_o(wrong1)
    );

    mole_spawner #(.MAX_ACTIVE(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .pulse_i(pulse),
        .seed_load_i(seed_load), .seed_i(seed), .whack_i(whack),
        .mole_position_o(mole3), .hit_vec_o(hit3), .miss_vec_o(miss3), .wrong_o(wrong3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         unit;
        logic [4:0] mole;
        logic [4:0] hit;
        logic [4:0] miss;
        logic       wrong;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] m_lfsr [2];
    logic [4:0] m_mole [2];
    int         m_age  [2][5];
    int         m_li   [2];
    bit         m_lv   [2];

    function automatic logic [7:0] step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_lfsr[u] = 8'h01;
            m_mole[u] = '0;
            m_li[u]   = 0;
            m_lv[u]   = 1'b0;
            for (int i = 0; i < 5; i++) m_age[u][i] = 0;
        end
    endtask

    task automatic model_cycle(input int u, input logic en, input logic pl, input logic sl,
                               input logic [7:0] sd, input logic [4:0] wh);
        exp_t       e;
        logic [7:0] nxt;
        int         cand, p, maxa;
        maxa    = (u == 0) ? 1 : 3;
        e.unit  = u;
        e.hit   = '0;
        e.miss  = '0;
        e.wrong = 1'b0;
        nxt     = step(m_lfsr[u]);
        if (!en) begin
            m_mole[u] = '0;
            m_lv[u]   = 1'b0;
            for (int i = 0; i < 5; i++) m_age[u][i] = 0;
        end else begin
            e.hit   = wh & m_mole[u];
            e.wrong = |(wh & ~m_mole[u]);
            for (int i = 0; i < 5; i++) begin
                if (e.hit[i]) begin
                    m_mole[u][i] = 1'b0;
                    m_age[u][i]  = 0;
                end
            end
            if (pl && !sl) begin
                for (int i = 0; i < 5; i++) begin
                    if (m_mole[u][i]) begin
                        m_age[u][i]++;
                        if (m_age[u][i] == 3) begin
                            m_mole[u][i] = 1'b0;
                            m_age[u][i]  = 0;
                            e.miss[i]    = 1'b1;
                        end
                    end
                end
                if ($countones(m_mole[u]) < maxa) begin
                    cand = int'(nxt) % 5;
                    if (m_lv[u] && cand == m_li[u]) cand = (cand + 1) % 5;
                    for (int k = 0; k < 5; k++) begin
                        p = (cand + k) % 5;
                        if (!m_mole[u][p]) begin
                            m_mole[u][p] = 1'b1;
                            m_age[u][p]  = 0;
                            m_li[u]      = p;
                            m_lv[u]      = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
        if (sl) m_lfsr[u] = (sd == 8'h00) ? 8'h01 : sd;
        else if (en && pl) m_lfsr[u] = nxt;
        e.mole = m_mole[u];
        sbq.push_back(e);
    endtask

    // Called at a falling edge; returns at the next falling edge with strobes cleared.
    task automatic cycle(input logic en, input logic pl, input logic sl,
                         input logic [7:0] sd, input logic [4:0] wh);
        exp_t e;
        enable = en; pulse = pl; seed_load = sl; seed = sd; whack = wh;
        model_cycle(0, en, pl, sl, sd, wh);
        model_cycle(1, en, pl, sl, sd, wh);
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.unit == 0) begin
                chk("u0 mole", 32'(mole1), 32'(e.mole));
                chk("u0 hit", 32'(hit1), 32'(e.hit));
                chk("u0 miss", 32'(miss1), 32'(e.miss));
                chk("u0 wrong", 32'(wrong1), 32'(e.wrong));
            end else begin
                chk("u1 mole", 32'(mole3), 32'(e.mole));
                chk("u1 hit", 32'(hit3), 32'(e.hit));
                chk("u1 miss", 32'(miss3), 32'(e.miss));
                chk("u1 wrong", 32'(wrong3), 32'(e.wrong));
            end
        end
        $display("t=%0t en=%b pl=%b sl=%b wh=%b | u0 mole=%b hit=%b miss=%b wr=%b | u1 mole=%b hit=%b miss=%b wr=%b",
                 $time, en, pl, sl, wh, mole1, hit1, miss1, wrong1, mole3, hit3, miss3, wrong3);
        @(negedge clk);
        pulse = 1'b0; seed_load = 1'b0; whack = '0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst mole1", 32'(mole1), 32'h0);
        chk("rst strobes1", 32'({hit1, miss1, wrong1}), 32'h0);
        chk("rst lfsr1", 32'(dut1.lfsr_q), 32'h01);
        chk("rst mole3", 32'(mole3), 32'h0);
        chk("rst strobes3", 32'({hit3, miss3, wrong3}), 32'h0);
        chk("rst lfsr3", 32'(dut3.lfsr_q), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; pulse = 1'b0; seed_load = 1'b0; seed = '0; whack = '0;
        @(negedge clk);
        do_reset();

        // first spawn, then expiry and respawn on pulse 4
        cycle(1, 1, 0, 8'h00, 5'b00000);
        chk("first mole", 32'(mole1), 32'b10000);
        chk("first lfsr", 32'(dut1.lfsr_q), 32'hB8);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        chk("expire miss", 32'(miss1), 32'b10000);
        chk("respawn mole", 32'(mole1), 32'b01000);
        chk("respawn lfsr", 32'(dut1.lfsr_q), 32'h17);
        cycle(1, 0, 0, 8'h00, 5'b00000);
        chk("miss one cycle", 32'(miss1), 32'h0);

        // hit
        do_reset();
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 0, 0, 8'h00, 5'b10000);
        chk("hit vec", 32'(hit1), 32'b10000);
        chk("hit mole", 32'(mole1), 32'h0);
        chk("hit nomiss", 32'({miss1, wrong1}), 32'h0);

        // wrong press, then repeat avoidance after zero-seed load
        do_reset();
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 0, 0, 8'h00, 5'b00001);
        chk("wrong flag", 32'(wrong1), 32'h1);
        chk("wrong nohit", 32'(hit1), 32'h0);
        chk("wrong mole", 32'(mole1), 32'b10000);
        cycle(1, 0, 0, 8'h00, 5'b10000);
        cycle(1, 0, 1, 8'h00, 5'b00000);
        chk("zero seed lfsr", 32'(dut1.lfsr_q), 32'h01);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        chk("repeat avoid", 32'(mole1), 32'b00001);

        // whack during the spawn cycle sees the pre-spawn state
        do_reset();
        cycle(1, 1, 0, 8'h00, 5'b10000);
        chk("spawn whack wrong", 32'(wrong1), 32'h1);
        chk("spawn whack nohit", 32'(hit1), 32'h0);
        chk("spawn whack mole", 32'(mole1), 32'b10000);

        // whack beats expiry on the same mole
        do_reset();
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b10000);
        chk("race hit", 32'(hit1), 32'b10000);
        chk("race nomiss", 32'(miss1), 32'h0);
        chk("race mole", 32'(mole1), 32'b01000);

        // three lit moles, multi-hit, disable, re-enable, reset mid-game
        do_reset();
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        chk("three lit", 32'(mole3), 32'b10110);
        cycle(1, 0, 0, 8'h00, 5'b00110);
        chk("multi hit", 32'(hit3), 32'b00110);
        chk("multi mole", 32'(mole3), 32'b10000);
        cycle(0, 1, 0, 8'h00, 5'b00000);
        chk("disable clear", 32'(mole3), 32'h0);
        chk("disable lfsr hold", 32'(dut3.lfsr_q), 32'h2E);
        cycle(1, 1, 0, 8'h00, 5'b00000);
        chk("reenable mole", 32'(mole3), 32'b01000);
        do_reset();

        // randomized play against the model
        for (int n = 0; n < 600; n++) begin
            logic       en, pl, sl;
            logic [7:0] sd;
            logic [4:0] wh;
            en = ($urandom % 16) != 0;
            pl = ($urandom % 3) == 0;
            sl = ($urandom % 40) == 0;
            sd = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
            wh = (($urandom % 3) == 0) ? 5'($urandom) : 5'b00000;
            cycle(en, pl, sl, sd, wh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
